// File: rtl/fft_loader_pkg.sv
// Shared types and constants for the fft_adc_loader block: FSM states,
// frame geometry and the one-hot bank decode.
package fft_loader_pkg;

  localparam int unsigned FRAME_N = 2048;
  localparam int unsigned CNT_W   = 11;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    START,
    WAIT_FFT
  } state_t;

  // Bank select from the top two counter bits; one bit per fft_top iWE_k.
  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    logic [3:0] oh;
    oh = '0;
    oh[bank] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fft_loader_cnt.sv
// 11-bit sample counter for one 2048-point frame: synchronous clear,
// increment, and a flag for the last sample slot (count 2047).
module fft_loader_cnt
  import fft_loader_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  // Wraps 2047 -> 0 naturally on the final increment of a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(FRAME_N - 1));

endmodule

// File: rtl/fft_adc_loader.sv
// Streams ADC samples into the four fft_top input banks, then pulses iSTART.
// Optional macro FFT_LOADER_OFFSET_BIN_EN: treat iDATA as offset-binary.
module fft_adc_loader
  import fft_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned BANKS  = 4
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iEN,
  input  logic              iVALID,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFFT_RDY,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W-1:0] oADDR_WR,
  output logic [BANKS-1:0]  oWE,
  output logic              oSTART,
  output logic              oBUSY,
  output logic              oOVF
);

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic [BANKS-1:0]  r_we;
  logic              r_start;
  logic              r_ovf;
  logic              r_rdy_d;

  logic [CNT_W-1:0]  w_cnt;
  logic              w_last;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_rdy_rise;
  logic [DATA_W-1:0] w_sample;

`ifdef FFT_LOADER_OFFSET_BIN_EN
  assign w_sample = {~iDATA[DATA_W-1], iDATA[DATA_W-2:0]};
`else
  assign w_sample = iDATA;
`endif

  assign w_rdy_rise = iFFT_RDY & ~r_rdy_d;

  // Abort in FILL clears the count even if a sample is written that cycle.
  assign w_cnt_clr = (r_state == IDLE) || ((r_state == FILL) && !iEN);
  assign w_cnt_inc = (r_state == FILL) && iEN && iVALID;

  fft_loader_cnt u_cnt (
    .i_clk  (iCLK),
    .i_rst  (iRESET),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_addr  <= '0;
      r_we    <= '0;
      r_start <= 1'b0;
      r_ovf   <= 1'b0;
      r_rdy_d <= 1'b0;
    end else begin
      r_we    <= '0;
      r_start <= 1'b0;
      r_rdy_d <= iFFT_RDY;
      case (r_state)
        IDLE: begin
          if (iEN) begin
            r_state <= FILL;
          end
        end
        FILL: begin
          if (iVALID) begin
            r_data <= w_sample;
            r_addr <= w_cnt[ADDR_W-1:0];
            r_we   <= bank_onehot(w_cnt[CNT_W-1 -: 2]);
          end
          if (!iEN) begin
            r_state <= IDLE;
          end else if (iVALID && w_last) begin
            r_state <= START;
          end
        end
        START: begin
          r_start <= 1'b1;
          r_state <= WAIT_FFT;
          if (iVALID) begin
            r_ovf <= 1'b1;
          end
        end
        WAIT_FFT: begin
          if (iVALID) begin
            r_ovf <= 1'b1;
          end
          if (w_rdy_rise) begin
            r_state <= iEN ? FILL : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oDATA    = r_data;
  assign oADDR_WR = r_addr;
  assign oWE      = r_we;
  assign oSTART   = r_start;
  assign oBUSY    = (r_state != IDLE);
  assign oOVF     = r_ovf;

endmodule

// File: tb/tb_fft_adc_loader.sv
// Randomized self-checking bench for fft_adc_loader against a frame-level
// model: sample n of a frame lands in bank n/512 at address n%512.
module tb_fft_adc_loader;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iEN = 1'b0;
  logic        iVALID = 1'b0;
  logic [15:0] iDATA = '0;
  logic        iFFT_RDY = 1'b0;
  logic [15:0] oDATA;
  logic [8:0]  oADDR_WR;
  logic [3:0]  oWE;
  logic        oSTART;
  logic        oBUSY;
  logic        oOVF;

  fft_adc_loader #(.DATA_W(16), .ADDR_W(9), .BANKS(4)) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iEN      (iEN),
    .iVALID   (iVALID),
    .iDATA    (iDATA),
    .iFFT_RDY (iFFT_RDY),
    .oDATA    (oDATA),
    .oADDR_WR (oADDR_WR),
    .oWE      (oWE),
    .oSTART   (oSTART),
    .oBUSY    (oBUSY),
    .oOVF     (oOVF)
  );

  always #5 iCLK = ~iCLK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [15:0] exp_mem [0:2047];
  logic [15:0] cap_mem [0:2047];
  bit          cap_v   [0:2047];
  int unsigned cap_cnt;
  int unsigned start_seen;
  int unsigned data_mode;
  logic        exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] xform(input logic [15:0] s);
`ifdef FFT_LOADER_OFFSET_BIN_EN
    return s ^ 16'h8000;
`else
    return s;
`endif
  endfunction

  function automatic logic [15:0] pick(input int unsigned n);
    logic [15:0] fixed [0:2];
    fixed[0] = 16'h8000;
    fixed[1] = 16'hFFFF;
    fixed[2] = 16'h0000;
    if (data_mode == 0) return 16'(n);
    if (data_mode == 2 && n < 3) return fixed[n];
    return 16'($urandom);
  endfunction

  // One clock; outputs observed 1 time unit after the edge, writes captured.
  task automatic tick();
    @(posedge iCLK);
    #1;
    if (oWE != 4'b0000) begin
      for (int b = 0; b < 4; b++) begin
        if (oWE[b]) begin
          cap_mem[b*512 + int'(oADDR_WR)] = oDATA;
          cap_v[b*512 + int'(oADDR_WR)]   = 1'b1;
        end
      end
      cap_cnt++;
    end
    if (oSTART) start_seen++;
  endtask

  task automatic new_frame();
    for (int i = 0; i < 2048; i++) begin
      cap_v[i]   = 1'b0;
      exp_mem[i] = '0;
      cap_mem[i] = '0;
    end
    cap_cnt    = 0;
    start_seen = 0;
  endtask

  // Samples n_from..n_to-1 of a frame, each followed one cycle later by its write.
  task automatic run_samples(input int unsigned gap, input int unsigned n_from,
                             input int unsigned n_to);
    logic [15:0] s;
    logic [3:0]  e_we;
    for (int unsigned n = n_from; n < n_to; n++) begin
      if (n != n_from) begin
        for (int unsigned g = 0; g < gap; g++) begin
          tick();
          chk("gap_we", {28'b0, oWE}, 32'h0);
        end
      end
      s = pick(n);
      exp_mem[n] = xform(s);
      iVALID = 1'b1;
      iDATA  = s;
      tick();
      iVALID = 1'b0;
      e_we = 4'b0001 << (n / 512);
      chk("wr", {3'b0, e_we, 9'(n % 512), xform(s)}, {3'b0, oWE, oADDR_WR, oDATA});
      chk("no_start_during_fill", {31'b0, oSTART}, 32'h0);
    end
  endtask

  task automatic frame_end_check();
    int unsigned diffs;
    tick();
    chk("start_pulse", {31'b0, oSTART}, 32'h1);
    chk("start_no_we", {28'b0, oWE}, 32'h0);
    tick();
    chk("start_one_cycle", {31'b0, oSTART}, 32'h0);
    chk("busy_wait_fft", {31'b0, oBUSY}, 32'h1);
    diffs = 0;
    for (int i = 0; i < 2048; i++) begin
      if (!cap_v[i] || cap_mem[i] !== exp_mem[i]) diffs++;
    end
    chk("ram_diffs", diffs, 32'h0);
    chk("write_count", cap_cnt, 32'd2048);
    chk("start_count", start_seen, 32'h1);
    chk("ovf", {31'b0, oOVF}, {31'b0, exp_ovf});
  endtask

  task automatic finish_fft(input logic en);
    iEN = en;
    iFFT_RDY = 1'b0;
    tick();
    iFFT_RDY = 1'b1;
    tick();
    chk("busy_after_rdy", {31'b0, oBUSY}, {31'b0, en});
    iFFT_RDY = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {3'b0, oDATA, oADDR_WR, oWE, oSTART, oBUSY, oOVF}, 32'h0);
  endtask

  initial begin
    exp_ovf = 1'b0;
    data_mode = 0;
    new_frame();

    iRESET = 1'b1;
    tick();
    tick();
    check_all_zero("reset_outputs");
    iRESET = 1'b0;

    // Arm cycle: a strobe while still IDLE is ignored entirely.
    iEN = 1'b1;
    iVALID = 1'b1;
    iDATA = 16'hDEAD;
    tick();
    iVALID = 1'b0;
    chk("arm_busy", {31'b0, oBUSY}, 32'h1);
    chk("idle_valid_no_we", {28'b0, oWE}, 32'h0);
    chk("idle_valid_no_ovf", {31'b0, oOVF}, 32'h0);

    // Frame A: back-to-back samples, data = n.
    new_frame();
    run_samples(0, 0, 2048);
    frame_end_check();
    finish_fft(1'b1);

    // Frame B: a sample every third cycle, random data.
    data_mode = 1;
    new_frame();
    run_samples(2, 0, 2048);
    frame_end_check();
    finish_fft(1'b1);

    // Abort after 700 samples; the strobe in the abort cycle is still written.
    new_frame();
    run_samples(0, 0, 700);
    iEN = 1'b0;
    iVALID = 1'b1;
    iDATA = 16'($urandom);
    tick();
    iVALID = 1'b0;
    chk("abort_wr", {3'b0, oWE, oADDR_WR, oDATA}, {3'b0, 4'b0010, 9'd188, xform(iDATA)});
    chk("abort_busy", {31'b0, oBUSY}, 32'h0);
    tick();
    chk("abort_busy2", {31'b0, oBUSY}, 32'h0);
    chk("abort_no_start", start_seen, 32'h0);

    // Re-arm; iFFT_RDY already high so it must not count as an edge later.
    iEN = 1'b1;
    iFFT_RDY = 1'b1;
    tick();
    chk("rearm_busy", {31'b0, oBUSY}, 32'h1);
    data_mode = 2;
    new_frame();
    run_samples(0, 0, 2048);
`ifdef FFT_LOADER_OFFSET_BIN_EN
    chk("obin_0", {16'b0, cap_mem[0]}, 32'h0000);
    chk("obin_1", {16'b0, cap_mem[1]}, 32'h7FFF);
    chk("obin_2", {16'b0, cap_mem[2]}, 32'h8000);
`else
    chk("pass_0", {16'b0, cap_mem[0]}, 32'h8000);
    chk("pass_1", {16'b0, cap_mem[1]}, 32'hFFFF);
    chk("pass_2", {16'b0, cap_mem[2]}, 32'h0000);
`endif
    frame_end_check();

    // Strobes in WAIT_FFT with iFFT_RDY held high: dropped, overflow set.
    for (int i = 0; i < 5; i++) begin
      iVALID = 1'b1;
      iDATA = 16'($urandom);
      tick();
      chk("wait_drop_we", {28'b0, oWE}, 32'h0);
      chk("wait_busy", {31'b0, oBUSY}, 32'h1);
    end
    iVALID = 1'b0;
    exp_ovf = 1'b1;
    chk("ovf_set", {31'b0, oOVF}, 32'h1);
    iFFT_RDY = 1'b0;
    tick();
    chk("wait_still", {31'b0, oBUSY}, 32'h1);
    iFFT_RDY = 1'b1;
    iVALID = 1'b1;
    iDATA = 16'h1234;
    tick();
    iVALID = 1'b0;
    chk("rise_drop_we", {28'b0, oWE}, 32'h0);
    chk("rise_busy", {31'b0, oBUSY}, 32'h1);
    chk("ovf_sticky", {31'b0, oOVF}, 32'h1);

    // Refill from count 0, then reset at sample 1300.
    data_mode = 1;
    new_frame();
    run_samples(0, 0, 1300);
    iRESET = 1'b1;
    iVALID = 1'b1;
    iDATA = 16'($urandom);
    tick();
    iVALID = 1'b0;
    check_all_zero("midframe_reset");
    chk("reset_no_start", start_seen, 32'h0);
    iRESET = 1'b0;
    exp_ovf = 1'b0;
    tick();
    chk("post_reset_busy", {31'b0, oBUSY}, 32'h1);
    new_frame();
    run_samples(0, 0, 2048);
    frame_end_check();
    finish_fft(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_adc_loader.md
Name: fft_adc_loader

Overview:
Upstream feeder for fft_top. Accepts a stream of signed 16-bit ADC samples and writes 2048-point frames into the four 512-word input RAM banks through the FFT's write ports (iDATA, iADDR_WR_x, iWE_x). When a frame is complete it pulses iSTART, then waits for oRDY. Frame order: sample n goes to bank n/512, address n%512. This is the same fill order the bench drives by hand today.

Parameters:
DATA_W, 16, ADC sample width and FFT input width.
ADDR_W, 9, per-bank address width (512 words).
BANKS, 4, number of input RAM banks. Fixed at 4 to match fft_top. Other values are not supported.

Ports:
iCLK  in  1  system clock.
iRESET  in  1  synchronous, active-high reset.
iEN  in  1  capture enable. Level-sensitive arm/abort.
iVALID  in  1  ADC sample strobe, one sample per asserted cycle.
iDATA  in  DATA_W  ADC sample.
iFFT_RDY  in  1  fft_top oRDY.
oDATA  out  DATA_W  to fft_top iDATA.
oADDR_WR  out  ADDR_W  to all four fft_top iADDR_WR_x (shared bus).
oWE  out  BANKS  one-hot write enable; bit k drives iWE_k.
oSTART  out  1  to fft_top iSTART, one-cycle pulse.
oBUSY  out  1  high in any state other than IDLE.
oOVF  out  1  sticky: a sample arrived while it could not be stored.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; iFFT_RDY edge register 0.
- FSM states: IDLE, FILL, START, WAIT_FFT.
- IDLE -> FILL when iEN=1. iVALID is ignored in IDLE and does not set oOVF.
- FILL, per accepted sample (iVALID=1):
  - Registered write on the next cycle: oDATA=sample, oADDR_WR=cnt[8:0], oWE=one-hot(cnt[10:9]), asserted for exactly 1 cycle.
  - Write latency is 1 cycle from iVALID.
  - 11-bit counter cnt increments per sample. Addresses wrap 511->0 while the bank index advances.
  - oWE is 0 on cycles without an accepted sample. oDATA and oADDR_WR hold their last values.
- FILL -> START when the sample with cnt=2047 is accepted. cnt wraps to 0.
- START lasts one cycle. oSTART=1 in the cycle after the last oWE pulse, never in the same cycle as any oWE.
- START -> WAIT_FFT unconditionally.
- WAIT_FFT leaves on a rising edge of iFFT_RDY (registered 0->1):
  - to FILL if iEN=1, otherwise to IDLE.
  - A level-high iFFT_RDY that is already asserted on entry does not count.
- Samples with iVALID=1 in START or WAIT_FFT are dropped and set oOVF=1.
- oOVF clears only on iRESET.
- iEN=0 during FILL: abort next cycle to IDLE, cnt=0, no oSTART. A sample in that same cycle is still written.
- iEN=0 during START or WAIT_FFT: the FFT run completes, then the FSM returns to IDLE.
- iRESET mid-frame: returns to reset values next edge. A partial frame is discarded and no oSTART is issued.
- Simultaneous iVALID with the iFFT_RDY rising edge in WAIT_FFT: the sample is dropped (oOVF=1). Acceptance starts in the following cycle.

Optional Feature:
FFT_LOADER_OFFSET_BIN_EN:
- Defined: iDATA is offset-binary (unsigned ADC). The loader inverts the MSB before writing, so 0x8000 -> 0x0000 and 0x0000 -> 0x8000.
- Undefined: iDATA is passed unchanged as two's complement.
- Latency is 1 cycle in both cases.

Decomposition:
- Package fft_loader_pkg holds:
  - state enum {IDLE, FILL, START, WAIT_FFT}
  - localparam FRAME_N=2048 and CNT_W=11
  - the one-hot bank decode function
- One sub-module, fft_loader_cnt: 11-bit frame counter with clear, increment and a last-sample flag (cnt==2047).
- FSM and output registers stay in the top.

Test Plan:
- Reset then iEN=1, 2048 consecutive iVALID with iDATA=n -> each bank k, address j receives k*512+j. oWE one-hot, 1 cycle after iVALID. oSTART exactly one pulse, 1 cycle after the last oWE. oOVF=0.
- iVALID every 3rd cycle for a full frame -> the same RAM contents. oWE pulses only on accepted samples. oSTART after sample 2047 only.
- iEN drops after 700 samples -> no oSTART, oBUSY=0 two cycles later. Re-arm and run a full frame -> the first write goes to bank 0, address 0.
- 5 iVALID pulses in WAIT_FFT with iFFT_RDY held high from entry -> oOVF=1, no oWE, still in WAIT_FFT. Drop iFFT_RDY, then raise it -> back to FILL at cnt 0.
- iRESET asserted at sample 1300 -> all outputs 0 next cycle, oOVF cleared. The next frame starts at bank 0, address 0.
- With FFT_LOADER_OFFSET_BIN_EN: input 0x8000, 0xFFFF, 0x0000 -> oDATA 0x0000, 0x7FFF, 0x8000. Without the macro, oDATA equals iDATA.
